// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
//            Holds the loader state encoding, byte/word geometry, the
//            byte-index width and the checksum width.
// Revision : 1.0 - initial release
// ============================================================================
package inst_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int BIDX_W     = $clog2(WORD_BYTES);
    localparam int CSUM_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

endpackage : inst_loader_pkg
`default_nettype wire

// File: rtl/loader_word_pack.sv
`default_nettype none
// ============================================================================
// Module   : loader_word_pack
// Purpose  : Shifts stream bytes MSB-first into a 32-bit word. word_full_o
//            is raised combinationally while the 4th byte of a word is being
//            accepted; word_o then carries the complete packed word.
// Ports    : clk          - system clock, rising edge
//            reset_n      - asynchronous active-low reset
//            clr_i        - synchronous clear of the partial word
//            byte_valid_i - byte_i is shifted in this cycle
//            byte_i       - stream byte
//            word_o       - packed word including the current byte
//            word_full_o  - current byte completes a word
// Revision : 1.0 - initial release
// ============================================================================
module loader_word_pack
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    logic [WORD_W-1:0] word_q;
    logic [BIDX_W-1:0] bidx_q;

    // Exposing the shifted value (not the stored one) lets the caller capture
    // the full word on the same edge that accepts its last byte.
    assign word_o      = {word_q[WORD_W-BYTE_W-1:0], byte_i};
    assign word_full_o = byte_valid_i && (bidx_q == BIDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            bidx_q <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            bidx_q <= '0;
        end else if (byte_valid_i) begin
            word_q <= word_o;
            bidx_q <= bidx_q + BIDX_W'(1);
        end
    end

endmodule : loader_word_pack
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Length-prefixed byte-stream loader for the instruction memory.
//            Packs bytes big-endian into words, issues one word-aligned write
//            per word and holds the processor in reset until the image is
//            complete.
// Config   : INST_LOADER_CHECKSUM_EN - when defined, a trailing XOR checksum
//            byte over the count and data bytes is verified in state CHK.
// Ports    : clk, reset_n         - clock / async active-low reset
//            in_valid, in_data    - stream byte input
//            in_ready             - byte accepted when in_valid && in_ready
//            reload               - restart from DONE or ERR
//            wr_en/wr_addr/wr_data- instruction-memory write port
//            cpu_reset            - processor hold (high unless DONE)
//            done, err            - load status
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;

    logic              accept;
    logic              pack_clr;
    logic              pack_valid;
    logic              word_full;
    logic [WORD_W-1:0] word;
    logic [31:0]       hdr_count;
    logic              last_word;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
`endif

    assign in_ready  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign accept    = in_valid && in_ready;
    assign hdr_count = 32'(in_data);
    assign last_word = (widx_q == (n_q - IDX_W'(1)));

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign cpu_reset = (state_q != S_DONE);

    loader_word_pack u_pack (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (pack_clr),
        .byte_valid_i (pack_valid),
        .byte_i       (in_data),
        .word_o       (word),
        .word_full_o  (word_full)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        pack_clr   = 1'b0;
        pack_valid = 1'b0;
        // Index advances on the edge that ends each write strobe.
        widx_d     = wr_en_q ? (widx_q + IDX_W'(1)) : widx_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_HDR;
            S_HDR: begin
                if (accept) begin
                    n_d      = IDX_W'(hdr_count);
                    widx_d   = '0;
                    pack_clr = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d   = in_data;
`endif
                    if (hdr_count == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else if (hdr_count > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                pack_valid = accept;
`ifdef INST_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                end
                // Leave DATA as soon as the last word is packed so the
                // checksum byte can follow with no bubble; the write strobe
                // is registered and still fires next cycle.
                if (word_full && last_word) begin
                    state_d = S_CHK;
                end
`else
                // Release only after the final write strobe, so the last word
                // is in memory before cpu_reset drops.
                if (wr_en_q && last_word) begin
                    state_d = S_DONE;
                end
`endif
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            widx_q    <= '0;
            n_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            n_q       <= n_d;
            wr_en_q   <= word_full;
            if (word_full) begin
                wr_addr_q <= ADDR_W'(widx_q) << 2;
                wr_data_q <= word;
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule : inst_mem_loader
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_loader
// Purpose  : Self-checking bench for inst_mem_loader. Expected writes are
//            queued from a byte-stream model; a monitor checks each strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0] u8;
    typedef u8 q_t[$];
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              reload = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_reset;
    logic              done;
    logic              err;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: got addr %h data %h, no write expected", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (wr_addr !== e.a || wr_data !== e.d) begin
                        errors++;
                        $display("FAIL wr: got addr %h data %h expected addr %h data %h",
                                 wr_addr, wr_data, e.a, e.d);
                    end
                end
            end
        end
    end

    function automatic u8 xor_of(input q_t s, input int cnt);
        u8 x = 8'h00;
        for (int i = 0; i < cnt; i++) x ^= s[i];
        return x;
    endfunction

    function automatic q_t add_csum(input q_t s);
        q_t r = s;
        if (CSUM && int'(s[0]) <= DEPTH) r.push_back(xor_of(s, s.size()));
        return r;
    endfunction

    task automatic send_byte(input u8 b);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        if (n > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (n - 1) @(negedge clk);
        end
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_in_ready", 32'(in_ready), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    endtask

    // Sends a complete stream, queues the writes the model predicts, and
    // checks status timing relative to the edge that accepts the last byte.
    task automatic run_load(input q_t s, input int gmin, input int gmax);
        int  n;
        bit  ok;
        wr_t w;
        n  = int'(s[0]);
        ok = (n <= DEPTH);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                w.a = 32'(4 * i);
                w.d = {s[1+4*i], s[2+4*i], s[3+4*i], s[4+4*i]};
                exp_q.push_back(w);
            end
            if (CSUM) ok = (xor_of(s, s.size() - 1) == s[s.size()-1]);
        end
        for (int i = 0; i < s.size(); i++) begin
            if (i > 0) gap($urandom_range(gmax, gmin));
            send_byte(s[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (!ok) begin
            chk("err_status", 32'(err), 32'd1);
            chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("err_done", 32'(done), 32'd0);
        end else if (!CSUM && n > 0) begin
            chk("t1_done", 32'(done), 32'd0);
            chk("t1_cpu_reset", 32'(cpu_reset), 32'd1);
            @(negedge clk);
            chk("t2_done", 32'(done), 32'd1);
            chk("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        end else begin
            chk("done_status", 32'(done), 32'd1);
            chk("done_cpu_reset", 32'(cpu_reset), 32'd0);
        end
        repeat (2) @(negedge clk);
        chk("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        q_t s;
        // Reset values while reset_n is low.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;

        // Two-word image, back-to-back bytes.
        s = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
        run_load(add_csum(s), 0, 0);

        // DONE ignores a held in_valid.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) begin
            @(negedge clk);
            chk("done_hold_in_ready", 32'(in_ready), 32'd0);
            chk("done_hold_done", 32'(done), 32'd1);
        end
        in_valid = 1'b0;
        do_reload();

        // Count above DEPTH.
        s = '{8'h21};
        run_load(s, 0, 0);
        do_reload();

        // Single word with 3 idle cycles between bytes.
        s = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(add_csum(s), 3, 3);
        do_reload();

        // Reset in the middle of a word.
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_wr_addr", wr_addr, 32'd0);
        chk("mid_rst_wr_data", wr_data, 32'd0);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        s = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(add_csum(s), 0, 0);

`ifdef INST_LOADER_CHECKSUM_EN
        do_reload();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0E};
        run_load(s, 0, 0);
        do_reload();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
        run_load(s, 0, 0);
`endif

        // Randomized images, including the empty, full and oversize counts.
        for (int it = 0; it < 25; it++) begin
            int r;
            int n;
            do_reload();
            r = $urandom_range(9, 0);
            if (r <= 5)      n = r;
            else if (r == 6) n = DEPTH;
            else if (r == 7) n = DEPTH + 1;
            else if (r == 8) n = $urandom_range(255, DEPTH + 2);
            else             n = $urandom_range(3, 1);
            s = '{};
            s.push_back(u8'(n));
            if (n <= DEPTH) begin
                for (int k = 0; k < 4 * n; k++) s.push_back(u8'($urandom));
            end
            s = add_csum(s);
            if (CSUM && n <= DEPTH && $urandom_range(3, 0) == 0) begin
                s[s.size()-1] = s[s.size()-1] ^ u8'($urandom_range(255, 1));
            end
            run_load(s, 0, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck run still reports.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_inst_mem_loader
`default_nettype wire
